// File: rtl/param_sum_accumulator.sv
// Batch accumulator for half-adder {carry, sum} results over valid/ready handshakes.
// Optional clamp-on-overflow behaviour enabled by defining PARAM_SUM_ACC_SATURATE_EN.
module param_sum_accumulator #(
    parameter int WIDTH     = 1,
    parameter int ACC_WIDTH = 8,
    parameter int N_SAMPLES = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_sum,
    input  logic                 in_carry,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] acc_out,
    output logic [CNT_WIDTH-1:0] carry_count,
    output logic                 overflow
);

    localparam int SCNT_W = $clog2(N_SAMPLES) + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t              r_state;
    logic [SCNT_W-1:0]   r_count;

    logic [ACC_WIDTH:0]   w_value;
    logic [ACC_WIDTH:0]   w_sum;
    logic [ACC_WIDTH-1:0] w_acc_next;
    logic [SCNT_W-1:0]    w_count_next;
    logic                 w_last;

    assign w_value      = {{(ACC_WIDTH - WIDTH){1'b0}}, in_carry, in_sum};
    assign w_sum        = {1'b0, acc_out} + w_value;
    assign w_count_next = r_count + 1'b1;
    assign w_last       = (w_count_next == SCNT_W'(N_SAMPLES));
    assign in_ready     = (r_state != DONE);

`ifdef PARAM_SUM_ACC_SATURATE_EN
    // Once clamped, any further non-zero beat carries out again, so all-ones holds.
    assign w_acc_next = w_sum[ACC_WIDTH] ? '1 : w_sum[ACC_WIDTH-1:0];
`else
    assign w_acc_next = w_sum[ACC_WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_state     <= IDLE;
            r_count     <= '0;
            acc_out     <= '0;
            carry_count <= '0;
            overflow    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (in_valid) begin
                        acc_out <= w_acc_next;
                        r_count <= w_count_next;
                        if (w_sum[ACC_WIDTH])
                            overflow <= 1'b1;
                        if (in_carry && (carry_count != '1))
                            carry_count <= carry_count + 1'b1;
                        if (w_last) begin
                            r_state   <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            r_state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state     <= IDLE;
                        r_count     <= '0;
                        acc_out     <= '0;
                        carry_count <= '0;
                        overflow    <= 1'b0;
                        out_valid   <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_param_sum_accumulator.sv
// Self-checking bench: four parameterisations share one stimulus bus; each scenario
// checks the instance it targets. Honours PARAM_SUM_ACC_SATURATE_EN like the design.
module tb_param_sum_accumulator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic in_valid = 1'b0;
    logic [0:0] in_sum = '0;
    logic in_carry = 1'b0;
    logic out_ready = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    // A: defaults (ACC 8, N 4, CNT 4)
    logic a_rdy, a_vld, a_ovf;
    logic [7:0] a_acc;
    logic [3:0] a_cc;
    // B: ACC 4, N 8
    logic b_rdy, b_vld, b_ovf;
    logic [3:0] b_acc;
    logic [3:0] b_cc;
    // C: N 1
    logic c_rdy, c_vld, c_ovf;
    logic [7:0] c_acc;
    logic [3:0] c_cc;
    // D: CNT 2, N 6
    logic d_rdy, d_vld, d_ovf;
    logic [7:0] d_acc;
    logic [1:0] d_cc;

    param_sum_accumulator u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(a_rdy),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(a_vld), .out_ready(out_ready),
        .acc_out(a_acc), .carry_count(a_cc), .overflow(a_ovf));

    param_sum_accumulator #(.WIDTH(1), .ACC_WIDTH(4), .N_SAMPLES(8), .CNT_WIDTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(b_rdy),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(b_vld), .out_ready(out_ready),
        .acc_out(b_acc), .carry_count(b_cc), .overflow(b_ovf));

    param_sum_accumulator #(.WIDTH(1), .ACC_WIDTH(8), .N_SAMPLES(1), .CNT_WIDTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(c_rdy),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(c_vld), .out_ready(out_ready),
        .acc_out(c_acc), .carry_count(c_cc), .overflow(c_ovf));

    param_sum_accumulator #(.WIDTH(1), .ACC_WIDTH(8), .N_SAMPLES(6), .CNT_WIDTH(2)) u_d (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(d_rdy),
        .in_sum(in_sum), .in_carry(in_carry), .out_valid(d_vld), .out_ready(out_ready),
        .acc_out(d_acc), .carry_count(d_cc), .overflow(d_ovf));

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sync_clear();
        clear = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        clear = 1'b0;
    endtask

    task automatic beat(input logic s, input logic c);
        in_valid = 1'b1; in_sum = s; in_carry = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({a_rdy, a_vld, a_acc, a_cc, a_ovf} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: rdy=%b vld=%b acc=%0d cc=%0d ovf=%b, want rdy=1 rest 0",
                     a_rdy, a_vld, a_acc, a_cc, a_ovf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        sync_clear();
        out_ready = 1'b1;
        beat(0, 0); beat(1, 0); beat(1, 0);
        n_checks++;
        if (a_vld !== 1'b0) begin
            n_fail++; $display("FAIL basic_early_valid: got %b want 0", a_vld);
        end
        beat(0, 1);
        n_checks++;
        if ({a_vld, a_acc, a_cc, a_ovf} !== {1'b1, 8'd4, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: vld=%b acc=%0d cc=%0d ovf=%b want 1/4/1/0",
                     a_vld, a_acc, a_cc, a_ovf);
        end
        tick();
        n_checks++;
        if ({a_vld, a_rdy, a_acc} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL basic_rearm: vld=%b rdy=%b acc=%0d want 0/1/0", a_vld, a_rdy, a_acc);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [3:0] exp_acc;
`ifdef PARAM_SUM_ACC_SATURATE_EN
        exp_acc = 4'd15;
`else
        exp_acc = 4'd8;
`endif
        sync_clear();
        for (int i = 0; i < 8; i++) beat(1, 1);
        n_checks++;
        if ({b_vld, b_acc, b_cc, b_ovf} !== {1'b1, exp_acc, 4'd8, 1'b1}) begin
            n_fail++;
            $display("FAIL overflow: vld=%b acc=%0d cc=%0d ovf=%b want 1/%0d/8/1",
                     b_vld, b_acc, b_cc, b_ovf, exp_acc);
        end
    endtask

    task automatic test_backpressure();
        sync_clear();
        for (int i = 0; i < 4; i++) beat(1, 0);
        in_valid = 1'b1; in_sum = 1'b0; in_carry = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if ({a_rdy, a_vld, a_acc, a_cc} !== {1'b0, 1'b1, 8'd4, 4'd0}) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: rdy=%b vld=%b acc=%0d cc=%0d want 0/1/4/0",
                         i, a_rdy, a_vld, a_acc, a_cc);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if ({a_vld, a_rdy, a_acc} !== {1'b0, 1'b1, 8'd0}) begin
            n_fail++;
            $display("FAIL hold_release: vld=%b rdy=%b acc=%0d want 0/1/0", a_vld, a_rdy, a_acc);
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({a_acc, a_cc} !== {8'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL pending_beat: acc=%0d cc=%0d want 2/1", a_acc, a_cc);
        end
        beat(0, 0); beat(0, 0); beat(0, 0);
        n_checks++;
        if ({a_vld, a_acc, a_cc} !== {1'b1, 8'd2, 4'd1}) begin
            n_fail++;
            $display("FAIL pending_batch: vld=%b acc=%0d cc=%0d want 1/2/1", a_vld, a_acc, a_cc);
        end
    endtask

    task automatic test_clear();
        sync_clear();
        beat(1, 0); beat(1, 0);
        clear = 1'b1; in_valid = 1'b1; in_sum = 1'b1; in_carry = 1'b1;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        n_checks++;
        if ({a_acc, a_cc, a_vld, a_rdy} !== {8'd0, 4'd0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL clear: acc=%0d cc=%0d vld=%b rdy=%b want 0/0/0/1", a_acc, a_cc, a_vld, a_rdy);
        end
        beat(1, 0); beat(1, 0); beat(1, 0);
        n_checks++;
        if (a_vld !== 1'b0) begin
            n_fail++; $display("FAIL clear_no_pulse: vld=%b want 0", a_vld);
        end
        beat(1, 0);
        n_checks++;
        if ({a_vld, a_acc} !== {1'b1, 8'd4}) begin
            n_fail++; $display("FAIL clear_fresh: vld=%b acc=%0d want 1/4", a_vld, a_acc);
        end
    endtask

    task automatic test_reset_mid();
        sync_clear();
        beat(1, 0); beat(1, 0); beat(1, 0);
        n_checks++;
        if (a_acc !== 8'd3) begin
            n_fail++; $display("FAIL mid_acc: acc=%0d want 3", a_acc);
        end
        rst_n = 1'b0; in_valid = 1'b1;
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        n_checks++;
        if ({a_rdy, a_vld, a_acc, a_cc, a_ovf} !== {1'b1, 1'b0, 8'd0, 4'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: rdy=%b vld=%b acc=%0d cc=%0d ovf=%b want 1/0/0/0/0",
                     a_rdy, a_vld, a_acc, a_cc, a_ovf);
        end
    endtask

    task automatic test_single();
        sync_clear();
        beat(1, 0);
        n_checks++;
        if ({c_vld, c_rdy, c_acc} !== {1'b1, 1'b0, 8'd1}) begin
            n_fail++; $display("FAIL single: vld=%b rdy=%b acc=%0d want 1/0/1", c_vld, c_rdy, c_acc);
        end
    endtask

    task automatic test_count_saturate();
        sync_clear();
        for (int i = 0; i < 6; i++) beat(0, 1);
        n_checks++;
        if ({d_vld, d_cc, d_acc, d_ovf} !== {1'b1, 2'd3, 8'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL cnt_sat: vld=%b cc=%0d acc=%0d ovf=%b want 1/3/12/0", d_vld, d_cc, d_acc, d_ovf);
        end
    endtask

    // Batch-level model for instance B: results derived from the total of accepted beats.
    task automatic test_random();
        int q[$];
        int carries, total;
        logic exp_vld;
        logic [3:0] exp_acc, exp_cc;
        logic exp_ovf;
        exp_vld = 1'b0; exp_acc = '0; exp_cc = '0; exp_ovf = 1'b0; carries = 0;
        sync_clear();
        for (int cyc = 0; cyc < 400; cyc++) begin
            n_checks++;
            if ({b_rdy, b_vld} !== {~exp_vld, exp_vld}) begin
                n_fail++;
                $display("FAIL rand_hs cyc%0d: rdy=%b vld=%b want %b/%b", cyc, b_rdy, b_vld, ~exp_vld, exp_vld);
            end
            if (exp_vld) begin
                n_checks++;
                if ({b_acc, b_cc, b_ovf} !== {exp_acc, exp_cc, exp_ovf}) begin
                    n_fail++;
                    $display("FAIL rand_result cyc%0d: acc=%0d cc=%0d ovf=%b want %0d/%0d/%b",
                             cyc, b_acc, b_cc, b_ovf, exp_acc, exp_cc, exp_ovf);
                end
            end
            clear     = ($urandom_range(0, 39) == 0);
            in_valid  = $urandom_range(0, 3) != 0;
            in_sum    = 1'($urandom_range(0, 1));
            in_carry  = 1'($urandom_range(0, 1));
            out_ready = $urandom_range(0, 2) == 0;
            if (clear) begin
                q.delete(); carries = 0; exp_vld = 1'b0;
            end else if (exp_vld) begin
                if (out_ready) exp_vld = 1'b0;
            end else if (in_valid) begin
                q.push_back(2 * int'(in_carry) + int'(in_sum));
                carries += int'(in_carry);
                if (q.size() == 8) begin
                    total = 0;
                    foreach (q[k]) total += q[k];
                    exp_ovf = (total >= 16);
`ifdef PARAM_SUM_ACC_SATURATE_EN
                    exp_acc = (total >= 16) ? 4'd15 : 4'(total);
`else
                    exp_acc = 4'(total % 16);
`endif
                    exp_cc  = 4'((carries > 15) ? 15 : carries);
                    exp_vld = 1'b1;
                    q.delete(); carries = 0;
                end
            end
            tick();
        end
        clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_backpressure();
        test_clear();
        test_reset_mid();
        test_single();
        test_count_saturate();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/param_sum_accumulator.md
Name: param_sum_accumulator

Overview:
- Downstream consumer of the parameterized half adder. Takes its {carry, sum} result over a valid/ready handshake.
- Accumulates N_SAMPLES results into a wider register, counts carry events and flags accumulator overflow.
- Presents the final total on an output handshake, then re-arms for the next batch.

Parameters:
- WIDTH, 1, width of the half adder's sum; input value is {in_carry, in_sum}, WIDTH+1 bits.
- ACC_WIDTH, 8, accumulator width; must be >= WIDTH+1.
- N_SAMPLES, 4, accepted beats per batch; must be >= 1.
- CNT_WIDTH, 4, width of carry_count; saturates at all-ones.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- clear  input  1  synchronous batch abort; returns to IDLE, zeroes all state.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  block can accept a beat.
- in_sum  input  WIDTH  half adder sum.
- in_carry  input  1  half adder carry.
- out_valid  output  1  batch result valid.
- out_ready  input  1  downstream accepts result.
- acc_out  output  ACC_WIDTH  accumulated total.
- carry_count  output  CNT_WIDTH  number of accepted beats with in_carry=1 in the batch.
- overflow  output  1  sticky: accumulator wrapped (or saturated) during the batch.

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low. All outputs are registered except in_ready, which is decoded from state.
- Reset (rst_n=0 at a clk edge): state=IDLE, acc_out=0, carry_count=0, overflow=0, out_valid=0, sample counter=0. in_ready is 1 in IDLE.
- States:
  - IDLE: in_ready=1; first accepted beat moves to ACCUM, or directly to DONE if N_SAMPLES=1.
  - ACCUM: in_ready=1; each accepted beat adds its value.
  - DONE: in_ready=0, out_valid=1; outputs are held stable until out_ready=1.
- Accept: a beat is taken on a clk edge with in_valid=1 and in_ready=1.
  - Beat value = zero-extend({in_carry,in_sum}) to ACC_WIDTH+1 bits.
  - New sum = acc_out + value; acc_out takes its low ACC_WIDTH bits.
  - overflow is set if bit ACC_WIDTH of the new sum is 1. It stays set until the batch ends.
  - carry_count increments when in_carry=1 and is held at all-ones once saturated.
- Sample counter: width $clog2(N_SAMPLES)+1; increments per accepted beat.
  - On the beat that makes it equal N_SAMPLES, the next state is DONE, and out_valid=1 from the following cycle.
  - Latency: out_valid rises 1 cycle after the last beat is accepted.
- DONE exit: on a clk edge with out_valid=1 and out_ready=1:
  - next state is IDLE;
  - acc_out, carry_count, overflow and the counter are zeroed;
  - out_valid drops to 0 the next cycle.
  - Results are readable only while out_valid=1.
- in_valid while in DONE: ignored, not consumed; upstream must hold the beat.
- clear=1: same effect as reset, from any state. It takes priority over a simultaneous input accept or output handshake; neither is consumed.
- Precedence when several events coincide: rst_n, then clear, then the handshakes.
- Reset or clear mid-batch: the partial batch is discarded; no out_valid pulse is produced.

Optional Feature:
- Macro: PARAM_SUM_ACC_SATURATE_EN.
- Defined: when a beat would carry out of ACC_WIDTH, acc_out clamps to all-ones and stays there for the rest of the batch; overflow is set as normal.
- Undefined: acc_out wraps modulo 2^ACC_WIDTH; overflow is set on the wrap.

Test Plan:
- WIDTH=1, N_SAMPLES=4, beats (sum,carry) = (0,0),(1,0),(1,0),(0,1), out_ready=1 -> out_valid=1 one cycle after the 4th beat; acc_out=4, carry_count=1, overflow=0. Next cycle out_valid=0, in_ready=1.
- ACC_WIDTH=4, N_SAMPLES=8, eight beats (1,1) -> macro undefined: acc_out=8, overflow=1, carry_count=8. Macro defined: acc_out=15, overflow=1.
- Batch complete with out_ready=0 for 5 cycles, in_valid=1 throughout -> in_ready=0 and outputs stable for 5 cycles. Result taken on the cycle out_ready=1. The pending beat is accepted in IDLE the following cycle.
- clear=1 asserted after 2 of 4 beats, coinciding with a valid beat -> that beat is not accepted; acc_out=0 and state IDLE next cycle; no out_valid pulse. A fresh 4-beat batch then completes normally.
- rst_n=0 for 1 cycle mid-ACCUM (acc_out=3) -> all outputs 0, in_ready=1 next cycle.
- N_SAMPLES=1, single beat (1,0) -> state goes straight to DONE; acc_out=1, out_valid=1 the next cycle.
- CNT_WIDTH=2, N_SAMPLES=6, all beats with carry=1 -> carry_count saturates at 3.
